// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file: default geometry and
// the hard-wired zero register index.
package regfile_sb_pkg;
  localparam int DEF_DW   = 32;
  localparam int DEF_NREG = 32;
  localparam int DEF_NRD  = 2;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, writeback, issue and scoreboard status.
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NREG = DEF_NREG,
  parameter int NRD  = DEF_NRD
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic [AW:0]       pend_cnt;
  logic              iss_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, pend_cnt, iss_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, pend_cnt, iss_err
  );
endinterface

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: zero-register force, writeback bypass and
// scoreboard busy indication.
module regfile_sb_rdport
  import regfile_sb_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NREG = DEF_NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic [AW-1:0]            i_rd_addr,
  input  logic [NREG-1:0][DW-1:0]  i_storage,
  input  logic [NREG-1:0]          i_pend,
  input  logic                     i_wr_en,
  input  logic [AW-1:0]            i_wr_addr,
  input  logic [DW-1:0]            i_wr_data,
  output logic [DW-1:0]            o_rd_data,
  output logic                     o_rd_busy
);
  logic w_zero;
  logic w_hit;

  assign w_zero = (i_rd_addr == AW'(ZERO_REG));
  assign w_hit  = i_wr_en && (i_wr_addr == i_rd_addr) && !w_zero;

  // A bypass hit both forwards the data and hides the pending bit it retires.
  assign o_rd_data = w_zero ? '0 : (w_hit ? i_wr_data : i_storage[i_rd_addr]);
  assign o_rd_busy = !w_zero && i_pend[i_rd_addr] && !w_hit;
endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register pending scoreboard, write bypass and
// registered pending count / double-issue error pulse.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NREG = DEF_NREG,
  parameter int NRD  = DEF_NRD
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int CW = AW + 1;

  logic [NREG-1:0][DW-1:0] r_storage;
  logic [NREG-1:0]         r_pend;
  logic [CW-1:0]           r_pend_cnt;
  logic                    r_iss_err;

  logic [NREG-1:0]         w_pend_nxt;
  logic [CW-1:0]           w_pend_cnt_nxt;
  logic                    w_iss_err_nxt;
  logic                    w_wr_ok;
  logic                    w_iss_ok;
  logic [NRD-1:0][DW-1:0]  w_rd_data;
  logic [NRD-1:0]          w_rd_busy;

  assign w_wr_ok  = bus.wr_en  && (bus.wr_addr  != AW'(ZERO_REG));
  assign w_iss_ok = bus.iss_en && (bus.iss_addr != AW'(ZERO_REG));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_ok)  w_pend_nxt[bus.wr_addr]  = 1'b0;
    if (w_iss_ok) w_pend_nxt[bus.iss_addr] = 1'b1;  // issue after clear: set wins

    w_iss_err_nxt = w_iss_ok && r_pend[bus.iss_addr] &&
                    !(w_wr_ok && (bus.wr_addr == bus.iss_addr));

    w_pend_cnt_nxt = '0;
    for (int k = 0; k < NREG; k++) w_pend_cnt_nxt += CW'(w_pend_nxt[k]);
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= '0;
      r_pend_cnt <= '0;
      r_iss_err  <= 1'b0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= w_pend_cnt_nxt;
      r_iss_err  <= w_iss_err_nxt;
    end
  end

  // NOTE: storage is flat flops that must read zero in reset, so it is reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_storage <= '0;
    end else if (w_wr_ok) begin
      r_storage[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    regfile_sb_rdport #(
      .DW   (DW),
      .NREG (NREG),
      .AW   (AW)
    ) u_rdport (
      .i_rd_addr (bus.rd_addr[g*AW +: AW]),
      .i_storage (r_storage),
      .i_pend    (r_pend),
      .i_wr_en   (bus.wr_en),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .o_rd_data (w_rd_data[g]),
      .o_rd_busy (w_rd_busy[g])
    );
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.rd_busy  = w_rd_busy;
  assign bus.pend_cnt = r_pend_cnt;
  assign bus.iss_err  = r_iss_err;
endmodule
